tlk2711_chan_hub: RTL and testbench

Register-bus fan-out, interrupt controller and PHY reset sequencer for NUM_CH TLK2711 channels. Decodes the PS-side register bus into per-channel strobes, returns read data through one registered mux, and aggregates each channel's tx/rx/loss interrupts into sticky, maskable, W1C pending bits. Also generates the external PHY reset pulse, which software can re-trigger, and a heartbeat LED. Sits between the MPSoC register bridge and the per-channel tlk2711 cores.

---
 rtl/tlk2711_hub_pkg.sv | 37 +++
 rtl/tlk2711_hub_irq.sv | 69 ++++++
 rtl/tlk2711_chan_hub.sv | 196 +++++++++++++++++++
 tb/tb_tlk2711_chan_hub.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlk2711_hub_pkg.sv
// Shared constants and types for the TLK2711 channel hub.
// Hub register offsets, ID/version, IRQ source indices, decode/read-select types.
package tlk2711_hub_pkg;

    localparam logic [7:0] HUB_ID       = 8'h00;
    localparam logic [7:0] HUB_IRQ_PEND = 8'h08;
    localparam logic [7:0] HUB_IRQ_MASK = 8'h10;
    localparam logic [7:0] HUB_PHY_CTRL = 8'h18;
    localparam logic [7:0] HUB_IRQ_RAW  = 8'h20;

    localparam logic [31:0] HUB_ID_MAGIC = 32'h544C4B48;
    localparam logic [7:0]  HUB_VERSION  = 8'h02;

    localparam int IRQ_TX     = 0;
    localparam int IRQ_RX     = 1;
    localparam int IRQ_LOSS   = 2;
    localparam int IRQ_PER_CH = 3;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_HUB,
        SEL_CH
    } rd_sel_e;

    // Result of decoding one bus address.
    typedef struct packed {
        logic        hub;
        logic        ch;
        logic [4:0]  idx;
        logic [15:0] off;
    } dec_t;

    function automatic logic [63:0] hub_id(input int num_ch);
        return {HUB_ID_MAGIC, 16'h0000, 8'(num_ch), HUB_VERSION};
    endfunction

endpackage

// File: rtl/tlk2711_hub_irq.sv
// Interrupt aggregation: rising-edge detect, sticky W1C pending, mask, per-channel OR.
// Ports: clk, rst, i_irq (levels), i_pend_wen/i_mask_wen + i_wdata, o_pend, o_mask, o_irq, o_irq_any.
module tlk2711_hub_irq
    import tlk2711_hub_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*NUM_CH-1:0]   i_irq,
    input  logic                  i_pend_wen,
    input  logic                  i_mask_wen,
    input  logic [3*NUM_CH-1:0]   i_wdata,
    output logic [3*NUM_CH-1:0]   o_pend,
    output logic [3*NUM_CH-1:0]   o_mask,
    output logic [NUM_CH-1:0]     o_irq,
    output logic                  o_irq_any
);

    logic [3*NUM_CH-1:0] r_prev;
    logic [3*NUM_CH-1:0] r_pend;
    logic [3*NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0]   r_irq;
    logic                r_irq_any;

    logic [3*NUM_CH-1:0] w_rise;
    logic [3*NUM_CH-1:0] w_clr;
    logic [3*NUM_CH-1:0] w_pend_nxt;
    logic [3*NUM_CH-1:0] w_act;
    logic [NUM_CH-1:0]   w_ch_irq;

    always_comb begin
        w_rise     = i_irq & ~r_prev;
        w_clr      = i_pend_wen ? i_wdata : '0;
        // Set is OR-ed after the clear so a simultaneous new edge survives.
        w_pend_nxt = (r_pend & ~w_clr) | w_rise;
        w_act      = r_pend & r_mask;
        w_ch_irq   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_irq[i] = w_act[IRQ_PER_CH*i + IRQ_TX]
                        | w_act[IRQ_PER_CH*i + IRQ_RX]
                        | w_act[IRQ_PER_CH*i + IRQ_LOSS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_pend    <= '0;
            r_mask    <= '0;
            r_irq     <= '0;
            r_irq_any <= 1'b0;
        end else begin
            r_prev    <= i_irq;
            r_pend    <= w_pend_nxt;
            if (i_mask_wen) begin
                r_mask <= i_wdata;
            end
            r_irq     <= w_ch_irq;
            r_irq_any <= |w_act;
        end
    end

    assign o_pend    = r_pend;
    assign o_mask    = r_mask;
    assign o_irq     = r_irq;
    assign o_irq_any = r_irq_any;

endmodule

// File: rtl/tlk2711_chan_hub.sv
// Register-bus fan-out, 2-stage read mux, IRQ hub, PHY reset sequencer and LED for TLK2711 channels.
// Ports: reg bus in (i_reg_*), per-channel strobes out (o_ch_*), i_ch_rdata/i_ch_irq in, o_irq*, o_phy_resetn, o_led.
module tlk2711_chan_hub
    import tlk2711_hub_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter int          DATA_WIDTH     = 64,
    parameter logic [15:0] CH_BASE        = 16'h0000,
    parameter logic [15:0] CH_STRIDE      = 16'h0100,
    parameter logic [15:0] HUB_BASE       = 16'hF000,
    parameter int          PHY_RST_CYCLES = 65535,
    parameter int          LED_DIV_BITS   = 27
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_reg_wen,
    input  logic                         i_reg_ren,
    input  logic [15:0]                  i_reg_waddr,
    input  logic [15:0]                  i_reg_raddr,
    input  logic [DATA_WIDTH-1:0]        i_reg_wdata,
    output logic [DATA_WIDTH-1:0]        o_reg_rdata,
    output logic [NUM_CH-1:0]            o_ch_wen,
    output logic [NUM_CH-1:0]            o_ch_ren,
    output logic [15:0]                  o_ch_waddr,
    output logic [15:0]                  o_ch_raddr,
    output logic [DATA_WIDTH-1:0]        o_ch_wdata,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_rdata,
    input  logic [3*NUM_CH-1:0]          i_ch_irq,
    output logic [NUM_CH-1:0]            o_irq,
    output logic                         o_irq_any,
    output logic                         o_phy_resetn,
    output logic                         o_led
);

    localparam int IRQ_W = 3 * NUM_CH;
    localparam int PHY_W = (PHY_RST_CYCLES > 0) ? $clog2(PHY_RST_CYCLES + 1) : 1;
    localparam logic [PHY_W-1:0] PHY_MAX = PHY_W'(PHY_RST_CYCLES);

    // Address arithmetic is done in 32 bits so region ends past 0xFFFF cannot wrap.
    function automatic dec_t decode(input logic [15:0] a);
        dec_t        d;
        logic [31:0] lo;
        d = '0;
        if (a[15:8] == HUB_BASE[15:8]) begin
            d.hub = 1'b1;
            d.off = {8'h00, a[7:0]};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                lo = 32'(CH_BASE) + 32'(i) * 32'(CH_STRIDE);
                if (32'(a) >= lo && 32'(a) < lo + 32'(CH_STRIDE)) begin
                    d.ch  = 1'b1;
                    d.idx = 5'(i);
                    d.off = a - lo[15:0];
                end
            end
        end
        return d;
    endfunction

    dec_t w_wdec;
    dec_t w_rdec;

    assign w_wdec = decode(i_reg_waddr);
    assign w_rdec = decode(i_reg_raddr);

    always_comb begin
        o_ch_wen = '0;
        o_ch_ren = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_ch_wen[i] = i_reg_wen && !rst && w_wdec.ch && (w_wdec.idx == 5'(i));
            o_ch_ren[i] = i_reg_ren && !rst && w_rdec.ch && (w_rdec.idx == 5'(i));
        end
    end

    assign o_ch_waddr = w_wdec.off;
    assign o_ch_raddr = w_rdec.off;
    assign o_ch_wdata = i_reg_wdata;

    logic w_hub_wen;
    logic w_pend_wen;
    logic w_mask_wen;
    logic w_phy_restart;

    assign w_hub_wen     = i_reg_wen && w_wdec.hub;
    assign w_pend_wen    = w_hub_wen && (i_reg_waddr[7:0] == HUB_IRQ_PEND);
    assign w_mask_wen    = w_hub_wen && (i_reg_waddr[7:0] == HUB_IRQ_MASK);
    assign w_phy_restart = w_hub_wen && (i_reg_waddr[7:0] == HUB_PHY_CTRL) && i_reg_wdata[0];

    logic [IRQ_W-1:0] w_pend;
    logic [IRQ_W-1:0] w_mask;

    tlk2711_hub_irq #(
        .NUM_CH(NUM_CH)
    ) u_irq (
        .clk        (clk),
        .rst        (rst),
        .i_irq      (i_ch_irq),
        .i_pend_wen (w_pend_wen),
        .i_mask_wen (w_mask_wen),
        .i_wdata    (i_reg_wdata[IRQ_W-1:0]),
        .o_pend     (w_pend),
        .o_mask     (w_mask),
        .o_irq      (o_irq),
        .o_irq_any  (o_irq_any)
    );

    logic [PHY_W-1:0] r_phy_cnt;
    logic             r_phy_resetn;

    always_ff @(posedge clk) begin
        if (rst || w_phy_restart) begin
            r_phy_cnt    <= '0;
            r_phy_resetn <= 1'b0;
        end else begin
            if (r_phy_cnt != PHY_MAX) begin
                r_phy_cnt <= r_phy_cnt + 1'b1;
            end
            r_phy_resetn <= (r_phy_cnt == PHY_MAX);
        end
    end

    assign o_phy_resetn = r_phy_resetn;

    logic [LED_DIV_BITS-1:0] r_led_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_cnt <= '0;
        end else begin
            r_led_cnt <= r_led_cnt + 1'b1;
        end
    end

    assign o_led = r_led_cnt[LED_DIV_BITS-1];

    logic [DATA_WIDTH-1:0] w_hub_rval;

    always_comb begin
        w_hub_rval = '0;
        case (i_reg_raddr[7:0])
            HUB_ID:       w_hub_rval = DATA_WIDTH'(hub_id(NUM_CH));
            HUB_IRQ_PEND: w_hub_rval = DATA_WIDTH'(w_pend);
            HUB_IRQ_MASK: w_hub_rval = DATA_WIDTH'(w_mask);
            HUB_PHY_CTRL: w_hub_rval = DATA_WIDTH'(r_phy_resetn);
            HUB_IRQ_RAW:  w_hub_rval = DATA_WIDTH'(i_ch_irq);
            default:      w_hub_rval = '0;
        endcase
    end

    logic                  r_rd_vld;
    rd_sel_e               r_rd_sel;
    logic [4:0]            r_rd_ch;
    logic [DATA_WIDTH-1:0] r_hub_rdata;
    logic [DATA_WIDTH-1:0] r_reg_rdata;
    logic [DATA_WIDTH-1:0] w_ch_rsel;

    // Stage 1: hub value is captured here so a concurrent W1C reads as pre-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld    <= 1'b0;
            r_rd_sel    <= SEL_NONE;
            r_rd_ch     <= '0;
            r_hub_rdata <= '0;
        end else begin
            r_rd_vld    <= i_reg_ren;
            r_rd_sel    <= w_rdec.hub ? SEL_HUB : (w_rdec.ch ? SEL_CH : SEL_NONE);
            r_rd_ch     <= w_rdec.idx;
            r_hub_rdata <= w_hub_rval;
        end
    end

    always_comb begin
        w_ch_rsel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_rd_ch == 5'(i)) begin
                w_ch_rsel = i_ch_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Stage 2: channel data arrives one cycle after the strobe, aligned with stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_rdata <= '0;
        end else if (r_rd_vld) begin
            case (r_rd_sel)
                SEL_HUB: r_reg_rdata <= r_hub_rdata;
                SEL_CH:  r_reg_rdata <= w_ch_rsel;
                default: r_reg_rdata <= '0;
            endcase
        end
    end

    assign o_reg_rdata = r_reg_rdata;

endmodule

// File: tb/tb_tlk2711_chan_hub.sv
// Self-checking bench for tlk2711_chan_hub (NUM_CH=4, short PHY pulse, short LED divider).
// Read results are checked against a scoreboard queue filled when reads are issued.
module tb_tlk2711_chan_hub;

    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int PRC = 16;
    localparam int LDB = 4;
    localparam logic [63:0] ID_EXP = 64'h544C4B48_0000_0402;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_reg_wen = 1'b0;
    logic              i_reg_ren = 1'b0;
    logic [15:0]       i_reg_waddr = '0;
    logic [15:0]       i_reg_raddr = '0;
    logic [DW-1:0]     i_reg_wdata = '0;
    logic [DW-1:0]     o_reg_rdata;
    logic [NCH-1:0]    o_ch_wen;
    logic [NCH-1:0]    o_ch_ren;
    logic [15:0]       o_ch_waddr;
    logic [15:0]       o_ch_raddr;
    logic [DW-1:0]     o_ch_wdata;
    logic [NCH*DW-1:0] i_ch_rdata = '0;
    logic [3*NCH-1:0]  i_ch_irq = '0;
    logic [NCH-1:0]    o_irq;
    logic              o_irq_any;
    logic              o_phy_resetn;
    logic              o_led;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic p1 = 1'b0;
    logic p2 = 1'b0;

    always #5 clk = ~clk;

    tlk2711_chan_hub #(
        .NUM_CH         (NCH),
        .DATA_WIDTH     (DW),
        .CH_BASE        (16'h0000),
        .CH_STRIDE      (16'h0100),
        .HUB_BASE       (16'hF000),
        .PHY_RST_CYCLES (PRC),
        .LED_DIV_BITS   (LDB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_reg_wen    (i_reg_wen),
        .i_reg_ren    (i_reg_ren),
        .i_reg_waddr  (i_reg_waddr),
        .i_reg_raddr  (i_reg_raddr),
        .i_reg_wdata  (i_reg_wdata),
        .o_reg_rdata  (o_reg_rdata),
        .o_ch_wen     (o_ch_wen),
        .o_ch_ren     (o_ch_ren),
        .o_ch_waddr   (o_ch_waddr),
        .o_ch_raddr   (o_ch_raddr),
        .o_ch_wdata   (o_ch_wdata),
        .i_ch_rdata   (i_ch_rdata),
        .i_ch_irq     (i_ch_irq),
        .o_irq        (o_irq),
        .o_irq_any    (o_irq_any),
        .o_phy_resetn (o_phy_resetn),
        .o_led        (o_led)
    );

    function automatic logic [63:0] chdat(input int ch, input logic [15:0] off);
        if (ch == 2 && off == 16'h0005) return 64'h0000_0000_0000_00A5;
        return 64'hC0DE_0000_0000_0000 | (64'(ch) << 32) | 64'(off);
    endfunction

    // Channel model: data one cycle after its read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (o_ch_ren[i]) i_ch_rdata[i*DW +: DW] <= chdat(i, o_ch_raddr);
        end
    end

    // Read monitor: a read sampled at edge N completes at edge N+1.
    always @(posedge clk) begin
        logic [63:0] e;
        if (rst) begin
            p1 = 1'b0;
            p2 = 1'b0;
        end else begin
            p2 = p1;
            p1 = i_reg_ren;
        end
        if (p2) begin
            #1;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rdata_unexpected got=%h want=<none>", o_reg_rdata);
            end else begin
                e = exp_q.pop_front();
                if (o_reg_rdata !== e) begin
                    n_fail++;
                    $display("FAIL rdata got=%h want=%h", o_reg_rdata, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d);
        i_reg_wen   = 1'b1;
        i_reg_waddr = a;
        i_reg_wdata = d;
        @(posedge clk);
        #1;
        i_reg_wen = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [63:0] e);
        exp_q.push_back(e);
        i_reg_ren   = 1'b1;
        i_reg_raddr = a;
        @(posedge clk);
        #1;
        i_reg_ren = 1'b0;
    endtask

    task automatic count_phy(input string nm);
        int n;
        n = 0;
        n_tests++;
        if (o_phy_resetn !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start got=%b want=0", nm, o_phy_resetn);
        end
        while (!o_phy_resetn && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_tests++;
        if (n != PRC + 1) begin
            n_fail++;
            $display("FAIL %s_len got=%0d want=%0d", nm, n, PRC + 1);
        end
    endtask

    task automatic test_reset();
        int n;
        logic led7, led8;
        rst = 1'b1;
        i_reg_wen = 1'b1;
        i_reg_waddr = 16'h0312;
        i_reg_ren = 1'b1;
        i_reg_raddr = 16'h0205;
        tick(2);
        n_tests++;
        if (o_ch_wen !== 4'b0000 || o_ch_ren !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_strobes got=%b/%b want=0000/0000", o_ch_wen, o_ch_ren);
        end
        n_tests++;
        if (o_reg_rdata !== 64'h0 || o_irq !== 4'h0 || o_irq_any !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outs got=%h/%b/%b want=0/0/0", o_reg_rdata, o_irq, o_irq_any);
        end
        n_tests++;
        if (o_phy_resetn !== 1'b0 || o_led !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_phy_led got=%b/%b want=0/0", o_phy_resetn, o_led);
        end
        i_reg_wen = 1'b0;
        i_reg_ren = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        led7 = 1'bx;
        led8 = 1'bx;
        while (!o_phy_resetn && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 7) led7 = o_led;
            if (n == 8) led8 = o_led;
        end
        n_tests++;
        if (n != PRC + 1) begin
            n_fail++;
            $display("FAIL phy_por_len got=%0d want=%0d", n, PRC + 1);
        end
        n_tests++;
        if (led7 !== 1'b0 || led8 !== 1'b1) begin
            n_fail++;
            $display("FAIL led_toggle got=%b%b want=01", led7, led8);
        end
    endtask

    task automatic test_decode();
        i_reg_wen   = 1'b1;
        i_reg_waddr = 16'h0312;
        i_reg_wdata = 64'h1122_3344_5566_7788;
        #1;
        n_tests++;
        if (o_ch_wen !== 4'b1000 || o_ch_waddr !== 16'h0012 || o_ch_wdata !== 64'h1122_3344_5566_7788) begin
            n_fail++;
            $display("FAIL dec_wr got=%b/%h want=1000/0012", o_ch_wen, o_ch_waddr);
        end
        i_reg_waddr = 16'h0400;
        #1;
        n_tests++;
        if (o_ch_wen !== 4'b0000) begin
            n_fail++;
            $display("FAIL dec_unmapped got=%b want=0000", o_ch_wen);
        end
        i_reg_waddr = 16'hF028;
        #1;
        n_tests++;
        if (o_ch_wen !== 4'b0000) begin
            n_fail++;
            $display("FAIL dec_hub got=%b want=0000", o_ch_wen);
        end
        i_reg_wen   = 1'b0;
        i_reg_raddr = 16'h0205;
        i_reg_ren   = 1'b1;
        #1;
        n_tests++;
        if (o_ch_ren !== 4'b0100 || o_ch_raddr !== 16'h0005) begin
            n_fail++;
            $display("FAIL dec_rd got=%b/%h want=0100/0005", o_ch_ren, o_ch_raddr);
        end
        i_reg_raddr = 16'h0400;
        #1;
        n_tests++;
        if (o_ch_ren !== 4'b0000) begin
            n_fail++;
            $display("FAIL dec_rd_unmapped got=%b want=0000", o_ch_ren);
        end
        i_reg_ren = 1'b0;
        tick(1);
    endtask

    task automatic test_reads();
        do_read(16'h0205, 64'hA5);
        do_read(16'h0400, 64'h0);
        do_read(16'hF000, ID_EXP);
        do_read(16'hF028, 64'h0);
        tick(3);
    endtask

    task automatic test_back_to_back();
        do_write(16'hF010, 64'h38);
        exp_q.push_back(ID_EXP);
        exp_q.push_back(chdat(1, 16'h0000));
        exp_q.push_back(64'h38);
        i_reg_ren   = 1'b1;
        i_reg_raddr = 16'hF000;
        tick(1);
        i_reg_raddr = 16'h0100;
        tick(1);
        i_reg_raddr = 16'hF010;
        tick(1);
        i_reg_ren = 1'b0;
        tick(3);
    endtask

    task automatic test_phy_restart();
        do_read(16'hF018, 64'h1);
        tick(2);
        do_write(16'hF018, 64'h1);
        count_phy("phy_restart");
        do_read(16'hF018, 64'h1);
        tick(3);
    endtask

    task automatic test_irq();
        do_write(16'hF010, 64'h38);
        i_ch_irq = 12'h010;
        tick(1);
        n_tests++;
        if (o_irq !== 4'b0000) begin
            n_fail++;
            $display("FAIL irq_early got=%b want=0000", o_irq);
        end
        tick(1);
        n_tests++;
        if (o_irq !== 4'b0010 || o_irq_any !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set got=%b/%b want=0010/1", o_irq, o_irq_any);
        end
        do_read(16'hF008, 64'h10);
        do_read(16'hF020, 64'h10);
        tick(3);
        do_write(16'hF008, 64'h10);
        n_tests++;
        if (o_irq !== 4'b0010) begin
            n_fail++;
            $display("FAIL irq_clr_early got=%b want=0010", o_irq);
        end
        tick(1);
        n_tests++;
        if (o_irq !== 4'b0000 || o_irq_any !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clr got=%b/%b want=0000/0", o_irq, o_irq_any);
        end
        tick(3);
        do_read(16'hF008, 64'h0);
        tick(3);
    endtask

    task automatic test_w1c_race();
        i_ch_irq = 12'h000;
        tick(1);
        i_ch_irq = 12'h010;
        do_write(16'hF008, 64'h10);
        tick(1);
        n_tests++;
        if (o_irq !== 4'b0010) begin
            n_fail++;
            $display("FAIL race_irq got=%b want=0010", o_irq);
        end
        do_read(16'hF008, 64'h10);
        exp_q.push_back(64'h10);
        i_reg_wen   = 1'b1;
        i_reg_waddr = 16'hF008;
        i_reg_wdata = 64'h10;
        i_reg_ren   = 1'b1;
        i_reg_raddr = 16'hF008;
        tick(1);
        i_reg_wen = 1'b0;
        i_reg_ren = 1'b0;
        do_read(16'hF008, 64'h0);
        tick(3);
        i_ch_irq = 12'h000;
        tick(1);
    endtask

    task automatic test_held_reset();
        i_ch_irq = 12'h001;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        do_read(16'hF008, 64'h1);
        do_read(16'hF010, 64'h0);
        tick(3);
        n_tests++;
        if (o_irq !== 4'b0000) begin
            n_fail++;
            $display("FAIL held_masked got=%b want=0000", o_irq);
        end
        do_write(16'hF008, 64'h1);
        tick(2);
        do_read(16'hF008, 64'h0);
        tick(3);
        i_ch_irq = 12'h000;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_reads();
        test_back_to_back();
        test_phy_restart();
        test_irq();
        test_w1c_race();
        test_held_reset();
        tick(4);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reads_pending got=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
